// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encoding,
// the blank-digit code and a width helper.
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD encoder with valid/ready on both
// sides and optional leading-zero blanking for a 7-segment display path.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W    = 17,
  parameter int DIGITS   = 6,
  parameter int BLANK_LZ = 0
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q;
  logic [BIN_W-1:0]   bin_sr_q;
  logic [BCD_W-1:0]   bcd_sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   out_bcd_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;
  logic [BCD_W-1:0]   bcd_fmt;
  logic               lead;
  logic               unused_top_bit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_sr_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  // The top BCD bit shifted out is always zero when the parameters are legal.
  assign unused_top_bit = bcd_adj[BCD_W-1];
  assign bcd_d = {bcd_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
  assign bin_d = {bin_sr_q[BIN_W-2:0], 1'b0};

  always_comb begin
    bcd_fmt = bcd_d;
    lead    = 1'b1;
    if (BLANK_LZ != 0) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (bcd_d[4*i +: 4] == 4'd0)) begin
          bcd_fmt[4*i +: 4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= IDLE;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_sr_q   <= in_bin;
            bcd_sr_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr_q <= bin_d;
          bcd_sr_q <= bcd_d;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            out_bcd_q   <= bcd_fmt;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          // Returning through IDLE gives the one-cycle gap before re-accept.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and streamed checks of bin_to_bcd_seq; a plain and a blanking
// instance share all inputs so every conversion exercises both variants.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [16:0] in_bin;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [23:0] a_out_bcd;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [23:0] b_out_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_W(17), .DIGITS(6), .BLANK_LZ(0)) dut_a (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .in_valid   (in_valid),
    .in_ready   (a_in_ready),
    .in_bin     (in_bin),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .out_bcd    (a_out_bcd),
    .busy       (a_busy)
  );

  bin_to_bcd_seq #(.BIN_W(17), .DIGITS(6), .BLANK_LZ(1)) dut_b (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .in_bin     (in_bin),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_bcd    (b_out_bcd),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] ref_bcd(input int v, input bit blank);
    logic [23:0] r;
    int          t;
    bit          lz;
    t  = v;
    lz = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    if (blank) begin
      for (int i = 5; i >= 1; i--) begin
        if (lz && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lz = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic start_conv(input logic [16:0] v, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok       = a_in_ready;
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!a_out_valid && lat < 40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    n_checks++; if (a_out_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_out_bcd: got %h expected 000000", a_out_bcd); end
    n_checks++; if (b_out_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_out_bcd_blank: got %h expected 000000", b_out_bcd); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    int lat;
    out_ready = 1'b1;
    start_conv(17'd86399, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept: in_ready got %b expected 1", ok); end
    n_checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_shift_flags: busy=%b in_ready=%b expected 1/0", a_busy, a_in_ready); end
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d expected 17", lat); end
    n_checks++; if (a_out_bcd !== 24'h086399) begin n_fail++; $display("FAIL basic_bcd: got %h expected 086399", a_out_bcd); end
    n_checks++; if (b_out_bcd !== 24'hF86399) begin n_fail++; $display("FAIL basic_bcd_blank: got %h expected f86399", b_out_bcd); end
    n_checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_hold_flags: in_ready=%b busy=%b expected 0/0", a_in_ready, a_busy); end
    @(posedge clk); #1;
    n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: out_valid=%b in_ready=%b expected 0/1", a_out_valid, a_in_ready); end
    n_checks++; if (a_out_bcd !== 24'h086399) begin n_fail++; $display("FAIL basic_bcd_kept: got %h expected 086399", a_out_bcd); end
  endtask

  task automatic test_zero_max;
    bit ok;
    int lat;
    out_ready = 1'b1;
    start_conv(17'd0, ok);
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL zero_latency: got %0d expected 17", lat); end
    n_checks++; if (a_out_bcd !== 24'h000000) begin n_fail++; $display("FAIL zero_bcd: got %h expected 000000", a_out_bcd); end
    n_checks++; if (b_out_bcd !== 24'hFFFFF0) begin n_fail++; $display("FAIL zero_bcd_blank: got %h expected fffff0", b_out_bcd); end
    @(posedge clk); #1;
    start_conv(17'd131071, ok);
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL max_latency: got %0d expected 17", lat); end
    n_checks++; if (a_out_bcd !== 24'h131071) begin n_fail++; $display("FAIL max_bcd: got %h expected 131071", a_out_bcd); end
    n_checks++; if (b_out_bcd !== 24'h131071) begin n_fail++; $display("FAIL max_bcd_blank: got %h expected 131071", b_out_bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_blank;
    logic [16:0] vin  [3];
    logic [23:0] expa [3];
    logic [23:0] expb [3];
    bit ok;
    int lat;
    vin[0] = 17'd7;      expa[0] = 24'h000007; expb[0] = 24'hFFFFF7;
    vin[1] = 17'd100000; expa[1] = 24'h100000; expb[1] = 24'h100000;
    vin[2] = 17'd1005;   expa[2] = 24'h001005; expb[2] = 24'hFF1005;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_conv(vin[i], ok);
      wait_done(lat);
      n_checks++; if (a_out_bcd !== expa[i]) begin n_fail++; $display("FAIL blank_plain[%0d]: got %h expected %h", i, a_out_bcd, expa[i]); end
      n_checks++; if (b_out_bcd !== expb[i]) begin n_fail++; $display("FAIL blank_lz[%0d]: got %h expected %h", i, b_out_bcd, expb[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int lat;
    out_ready = 1'b0;
    start_conv(17'd12345, ok);
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL bp_latency: got %0d expected 17", lat); end
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 17'd999;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_bcd !== 24'h012345) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b bcd=%h expected 1/0/012345", i, a_out_valid, a_in_ready, a_out_bcd);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL bp_gap: out_valid=%b in_ready=%b busy=%b expected 0/1/0", a_out_valid, a_in_ready, a_busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reaccept: busy=%b in_ready=%b expected 1/0", a_busy, a_in_ready); end
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL bp_second_latency: got %0d expected 17", lat); end
    n_checks++; if (a_out_bcd !== 24'h000999) begin n_fail++; $display("FAIL bp_second_bcd: got %h expected 000999", a_out_bcd); end
    n_checks++; if (b_out_bcd !== 24'hFFF999) begin n_fail++; $display("FAIL bp_second_bcd_blank: got %h expected fff999", b_out_bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int lat;
    out_ready = 1'b1;
    start_conv(17'd54321, ok);
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", a_busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: out_valid=%b busy=%b in_ready=%b expected 0/0/1", a_out_valid, a_busy, a_in_ready); end
    n_checks++; if (a_out_bcd !== 24'h0 || b_out_bcd !== 24'h0) begin n_fail++; $display("FAIL rst_mid_bcd: got %h/%h expected 000000/000000", a_out_bcd, b_out_bcd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_conv(17'd54321, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_mid_accept: in_ready got %b expected 1", ok); end
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected 17", lat); end
    n_checks++; if (a_out_bcd !== 24'h054321) begin n_fail++; $display("FAIL rst_mid_bcd_after: got %h expected 054321", a_out_bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    localparam int N = 1000;
    logic [16:0] q[$];
    logic [16:0] cur, e;
    logic [23:0] ca, cb;
    bit acc, otr, prev_ov;
    int cyc, acc_cyc, sent, got;
    cyc = 0; acc_cyc = 0; sent = 0; got = 0;
    prev_ov = a_out_valid;
    cur = 17'd131071;
    while (got < N && cyc < 60000) begin
      @(negedge clk);
      if (a_out_valid && !prev_ov) begin
        n_checks++;
        if (cyc - acc_cyc !== 17) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 17", cyc - acc_cyc); end
      end
      prev_ov   = a_out_valid;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < N);
      in_bin    = cur;
      acc = in_valid && a_in_ready;
      otr = a_out_valid && out_ready;
      ca  = a_out_bcd;
      cb  = b_out_bcd;
      @(posedge clk);
      cyc++;
      if (acc) begin
        q.push_back(in_bin);
        acc_cyc = cyc;
        sent++;
        cur = (sent == 1) ? 17'd0 : 17'($urandom_range(0, 131071));
      end
      if (otr) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_output: got %h expected none", ca);
        end else begin
          e = q.pop_front();
          got++;
          if (ca !== ref_bcd(int'(e), 1'b0)) begin n_fail++; $display("FAIL b2b_bcd in=%0d: got %h expected %h", e, ca, ref_bcd(int'(e), 1'b0)); end
          n_checks++;
          if (cb !== ref_bcd(int'(e), 1'b1)) begin n_fail++; $display("FAIL b2b_bcd_blank in=%0d: got %h expected %h", e, cb, ref_bcd(int'(e), 1'b1)); end
        end
      end
    end
    #1;
    in_valid = 1'b0;
    n_checks++; if (got !== N || sent !== N || q.size() !== 0) begin n_fail++; $display("FAIL b2b_count: got=%0d sent=%0d pending=%0d expected %0d/%0d/0", got, sent, q.size(), N, N); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_max();
    test_blank();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
